if_id_queue: RTL

Parametrised successor to the IF/ID pipeline register. It decouples instruction fetch from decode by putting a DEPTH-entry {pc, instruction} FIFO in front of the registered IF/ID output. While decode is stalled, fetch can keep delivering instructions, and an empty queue bypasses straight to the output register so the old one-cycle latency is kept. It honours the existing stall_C/flush_C control vectors and delay-slot squash, and adds occupancy and overflow reporting.

---
 rtl/if_id_queue.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/if_id_queue.sv
// if_id_queue
// Decoupling queue between instruction fetch and decode. A DEPTH-entry
// {pc, instruction} FIFO sits in front of the registered IF/ID output.
// When the FIFO is empty, an accepted push bypasses straight into the
// output register, which keeps the one-cycle fetch-to-decode latency.
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous active-low reset
//   stall_C/flush_C  pipeline control vectors; bit STAGE_IDX controls this stage
//   slot_flush       squash the instruction that would advance this cycle
//   push_valid       fetch presents pc_in / instructions_in
//   push_ready       FIFO not full (derived from the registered count only)
//   pc_out, instructions_out, bubble_out   registered IF/ID output
//   count_out        FIFO occupancy, not counting the output register
//   overflow_out     sticky: a push was attempted while the FIFO was full
module if_id_queue #(
  parameter int PC_W      = 32,
  parameter int INSTR_W   = 32,
  parameter int DEPTH     = 4,
  parameter int CTRL_W    = 4,
  parameter int STAGE_IDX = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CTRL_W-1:0]          stall_C,
  input  logic [CTRL_W-1:0]          flush_C,
  input  logic                       slot_flush,
  input  logic                       push_valid,
  input  logic [PC_W-1:0]            pc_in,
  input  logic [INSTR_W-1:0]         instructions_in,
  output logic                       push_ready,
  output logic [PC_W-1:0]            pc_out,
  output logic [INSTR_W-1:0]         instructions_out,
  output logic                       bubble_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out,
  output logic                       overflow_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int ENT_W = PC_W + INSTR_W;

  logic [ENT_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic               r_bubble;
  logic               r_overflow;

  logic               w_stall;
  logic               w_flush;
  logic               w_has_head;
  logic               w_accept;
  logic               w_store;
  logic [ENT_W-1:0]   w_head_ent;
  logic               w_unused_ctrl;

  assign w_stall    = stall_C[STAGE_IDX];
  assign w_flush    = flush_C[STAGE_IDX];
  assign w_has_head = (r_count != '0);
  assign push_ready = (r_count != CNT_W'(DEPTH));
  assign w_accept   = push_valid & push_ready;
  assign w_head_ent = r_mem[r_head];

  // Only bits STAGE_IDX of the control vectors belong to this stage.
  assign w_unused_ctrl = ^{stall_C, flush_C};

  // An accepted push is stored unless it is flushed, or the queue is empty
  // and the stage advances (bypass, or the bypassed input is squashed).
  assign w_store = rst & ~w_flush & w_accept & (w_stall | w_has_head);

  // Storage array kept free of reset so it can map onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem[r_tail] <= {pc_in, instructions_in};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_pc       <= '0;
      r_instr    <= '0;
      r_bubble   <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      // A push against a full queue is lost even if a pop happens this cycle.
      if (!w_flush && push_valid && !push_ready) begin
        r_overflow <= 1'b1;
      end

      if (w_flush) begin
        r_head   <= '0;
        r_tail   <= '0;
        r_count  <= '0;
        r_pc     <= '0;
        r_instr  <= '0;
        r_bubble <= 1'b1;
      end else if (w_stall) begin
        if (w_accept) begin
          r_tail  <= r_tail + PTR_W'(1);
          r_count <= r_count + CNT_W'(1);
        end
      end else begin
        // Stage advances: the candidate is the head if any, else the input.
        if (w_has_head) begin
          r_head <= r_head + PTR_W'(1);
        end
        if (w_store) begin
          r_tail <= r_tail + PTR_W'(1);
        end
        if (w_has_head && !w_accept) begin
          r_count <= r_count - CNT_W'(1);
        end

        if (slot_flush) begin
          r_pc     <= '0;
          r_instr  <= '0;
          r_bubble <= 1'b1;
        end else if (w_has_head) begin
          r_pc     <= w_head_ent[ENT_W-1:INSTR_W];
          r_instr  <= w_head_ent[INSTR_W-1:0];
          r_bubble <= 1'b0;
        end else if (w_accept) begin
          r_pc     <= pc_in;
          r_instr  <= instructions_in;
          r_bubble <= 1'b0;
        end else begin
          r_pc     <= '0;
          r_instr  <= '0;
          r_bubble <= 1'b1;
        end
      end
    end
  end

  assign pc_out           = r_pc;
  assign instructions_out = r_instr;
  assign bubble_out       = r_bubble;
  assign count_out        = r_count;
  assign overflow_out     = r_overflow;

endmodule
